// File: rtl/tlb_pkg.sv
// Shared types for the MMU translation responder: TLB entry layout, exception codes,
// invalidate opcodes and the invalidate sweep states.
package tlb_pkg;

  localparam int unsigned PAGE_OFFSET_W = 12;
  localparam int unsigned ASID_W        = 10;
  localparam int unsigned VPN_W         = 20;
  localparam int unsigned PPN_W         = 20;

  typedef struct packed {
    logic              e;
    logic              g;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  vpn;
    logic [PPN_W-1:0]  ppn;
    logic              v;
    logic              d;
    logic [1:0]        plv;
    logic [1:0]        mat;
  } tlb_entry_t;

  typedef enum logic [2:0] {
    ExcNone = 3'd0,
    ExcTlbr = 3'd1,
    ExcPil  = 3'd2,
    ExcPis  = 3'd3,
    ExcPme  = 3'd4,
    ExcPpi  = 3'd5
  } tlb_exc_e;

  typedef enum logic [1:0] {
    InvAll    = 2'd0,
    InvAsid   = 2'd1,
    InvAsidVa = 2'd2,
    InvNop    = 2'd3
  } tlb_inv_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDone
  } inv_state_e;

endpackage

// File: rtl/tlb_entry_match.sv
// Fully associative CAM compare over all TLB entries with a lowest-index-wins
// priority encoder.
module tlb_entry_match
  import tlb_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = 16,
  parameter int unsigned IDX_W         = $clog2(TLB_ENTRY_NUM)
) (
  input  tlb_entry_t        entries [TLB_ENTRY_NUM],
  input  logic [VPN_W-1:0]  vpn,
  input  logic [ASID_W-1:0] asid,
  output logic              hit,
  output logic [IDX_W-1:0]  hit_idx
);

  logic [TLB_ENTRY_NUM-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < int'(TLB_ENTRY_NUM); i++) begin
      match[i] = entries[i].e && (entries[i].vpn == vpn) &&
                 (entries[i].g || (entries[i].asid == asid));
    end
  end

  // Walk downwards so the lowest matching index is the last one assigned.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(TLB_ENTRY_NUM) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/tlb_xlate_responder.sv
// MMU translation responder: owns the TLB entry array, answers lookups one cycle after
// acceptance, and runs the one-entry-per-cycle invalidate sweep.
module tlb_xlate_responder
  import tlb_pkg::*;
#(
  parameter int unsigned TLB_ENTRY_NUM = 16,
  parameter int unsigned ASID_WIDTH    = ASID_W,
  parameter int unsigned VPN_WIDTH     = VPN_W,
  parameter int unsigned PPN_WIDTH     = PPN_W,
  localparam int unsigned IDX_W        = $clog2(TLB_ENTRY_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_vaddr,
  input  logic [ASID_WIDTH-1:0] req_asid,
  input  logic [1:0]            req_plv,
  input  logic                  req_store,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_paddr,
  output logic [1:0]            rsp_mat,
  output tlb_exc_e              rsp_exc,
  input  logic                  wr_valid,
  input  logic [IDX_W-1:0]      wr_idx,
  input  tlb_entry_t            wr_entry,
  input  logic                  inv_valid,
  output logic                  inv_ready,
  input  logic [1:0]            inv_op,
  input  logic [ASID_WIDTH-1:0] inv_asid,
  input  logic [31:0]           inv_vaddr,
  output logic                  inv_done
);

  tlb_entry_t entries_q [TLB_ENTRY_NUM];

  inv_state_e            state_q;
  logic [IDX_W-1:0]      sweep_idx_q;
  tlb_inv_op_e           inv_op_q;
  logic [ASID_WIDTH-1:0] inv_asid_q;
  logic [VPN_WIDTH-1:0]  inv_vpn_q;
  logic                  inv_done_q;

  logic                  rsp_valid_q;
  logic [31:0]           rsp_paddr_q;
  logic [1:0]            rsp_mat_q;
  tlb_exc_e              rsp_exc_q;

  logic                  hit;
  logic [IDX_W-1:0]      hit_idx;
  tlb_entry_t            hit_entry;
  tlb_exc_e              exc_d;
  logic [31:0]           paddr_d;
  logic [1:0]            mat_d;
  logic                  req_fire;
  logic                  sweep_sel;
  logic                  unused_inv_offset;

  assign unused_inv_offset = ^inv_vaddr[PAGE_OFFSET_W-1:0];

  // A simultaneous invalidate takes priority over a new lookup.
  assign req_ready = (state_q == StIdle) && (!rsp_valid_q || rsp_ready) && !inv_valid;
  assign inv_ready = (state_q == StIdle);
  assign req_fire  = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_paddr = rsp_paddr_q;
  assign rsp_mat   = rsp_mat_q;
  assign rsp_exc   = rsp_exc_q;
  assign inv_done  = inv_done_q;

  tlb_entry_match #(
    .TLB_ENTRY_NUM(TLB_ENTRY_NUM),
    .IDX_W        (IDX_W)
  ) u_match (
    .entries(entries_q),
    .vpn    (req_vaddr[31:PAGE_OFFSET_W]),
    .asid   (req_asid),
    .hit    (hit),
    .hit_idx(hit_idx)
  );

  assign hit_entry = entries_q[hit_idx];

  always_comb begin
    exc_d = ExcNone;
    if (!hit) begin
      exc_d = ExcTlbr;
    end else if (!hit_entry.v) begin
      exc_d = req_store ? ExcPis : ExcPil;
    end else if (req_plv > hit_entry.plv) begin
      exc_d = ExcPpi;
    end else if (req_store && !hit_entry.d) begin
      exc_d = ExcPme;
    end
    paddr_d = (exc_d == ExcNone) ? {hit_entry.ppn, req_vaddr[PAGE_OFFSET_W-1:0]} : 32'h0;
    mat_d   = hit ? hit_entry.mat : 2'b00;
  end

  always_comb begin
    sweep_sel = 1'b0;
    unique case (inv_op_q)
      InvAll:    sweep_sel = 1'b1;
      InvAsid:   sweep_sel = !entries_q[sweep_idx_q].g &&
                             (entries_q[sweep_idx_q].asid == inv_asid_q);
      InvAsidVa: sweep_sel = !entries_q[sweep_idx_q].g &&
                             (entries_q[sweep_idx_q].asid == inv_asid_q) &&
                             (entries_q[sweep_idx_q].vpn == inv_vpn_q);
      InvNop:    sweep_sel = 1'b0;
      default:   sweep_sel = 1'b0;
    endcase
  end

  // The write is applied after the sweep clear so a same-index write survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(TLB_ENTRY_NUM); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      if ((state_q == StSweep) && sweep_sel) begin
        entries_q[sweep_idx_q].e <= 1'b0;
      end
      if (wr_valid) begin
        entries_q[wr_idx] <= wr_entry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sweep_idx_q <= '0;
      inv_op_q    <= InvNop;
      inv_asid_q  <= '0;
      inv_vpn_q   <= '0;
      inv_done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          inv_done_q <= 1'b0;
          if (inv_valid) begin
            state_q     <= StSweep;
            sweep_idx_q <= '0;
            inv_op_q    <= tlb_inv_op_e'(inv_op);
            inv_asid_q  <= inv_asid;
            inv_vpn_q   <= inv_vaddr[31:PAGE_OFFSET_W];
          end
        end
        StSweep: begin
          sweep_idx_q <= sweep_idx_q + 1'b1;
          if (sweep_idx_q == IDX_W'(TLB_ENTRY_NUM - 1)) begin
            state_q    <= StDone;
            inv_done_q <= 1'b1;
          end
        end
        StDone: begin
          state_q    <= StIdle;
          inv_done_q <= 1'b0;
        end
        default: begin
          state_q    <= StIdle;
          inv_done_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_paddr_q <= '0;
      rsp_mat_q   <= '0;
      rsp_exc_q   <= ExcNone;
    end else if (req_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_paddr_q <= paddr_d;
      rsp_mat_q   <= mat_d;
      rsp_exc_q   <= exc_d;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

endmodule
